collision_game_fsm: RTL

- Upstream game-control stage for the score display.
- Detects player/obstacle pixel overlap during the active video scan and sequences the game through idle, run, hit-flash and game-over states.
- Drives `hit`, which freezes the score counter, and `game_reset`, a one-cycle restart pulse that clears the score.
- Also debounces the restart key.

---
 rtl/collision_game_fsm.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/collision_game_fsm.sv
// Game-control stage: counts player/obstacle overlap per frame, debounces the
// restart key and sequences IDLE -> RUN -> HIT -> GAMEOVER for the score block.
module collision_game_fsm #(
    parameter int H_LAST       = 1687,
    parameter int V_LAST       = 1065,
    parameter int OVERLAP_MIN  = 16,
    parameter int HIT_FRAMES   = 120,
    parameter int FLASH_FRAMES = 8,
    parameter int DEB_CYCLES   = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] display_col,
    input  logic [10:0] display_row,
    input  logic        visible,
    input  logic        player_visible,
    input  logic        obstacle_visible,
    input  logic        start_key_n,
    output logic        hit,
    output logic        game_reset,
    output logic        flash,
    output logic        frame_end,
    output logic [1:0]  game_state
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int FRM_W = $clog2(HIT_FRAMES + 1);
    localparam int FLS_W = $clog2(FLASH_FRAMES + 1);

    localparam logic [11:0]      H_LAST_C      = 12'(H_LAST);
    localparam logic [10:0]      V_LAST_C      = 11'(V_LAST);
    localparam logic [15:0]      OVERLAP_MIN_C = 16'(OVERLAP_MIN);
    localparam logic [DEB_W-1:0] DEB_LAST_C    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [FRM_W-1:0] HIT_LAST_C    = FRM_W'(HIT_FRAMES - 1);
    localparam logic [FLS_W-1:0] FLASH_LAST_C  = FLS_W'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_HIT      = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    state_t             state_r;
    logic               hit_r;
    logic               game_reset_r;
    logic               flash_r;
    logic               frame_end_r;
    logic [15:0]        overlap_cnt_r;
    logic [FRM_W-1:0]   frame_cnt_r;
    logic [FLS_W-1:0]   flash_cnt_r;
    logic               key_meta_r;
    logic               key_sync_r;
    logic               deb_key_n_r;
    logic [DEB_W-1:0]   deb_cnt_r;
    logic               press_r;

    logic               frame_end_s;
    logic               overlap_s;
    logic               collide_s;

    // FSM decisions use the raw last-pixel match so the state change lines up
    // with the registered frame_end pulse.
    assign frame_end_s = (display_row == V_LAST_C) && (display_col == H_LAST_C);
    assign overlap_s   = visible && player_visible && obstacle_visible;
    assign collide_s   = (overlap_cnt_r >= OVERLAP_MIN_C);

    assign hit        = hit_r;
    assign game_reset = game_reset_r;
    assign flash      = flash_r;
    assign frame_end  = frame_end_r;
    assign game_state = state_r;

    // Frame-end pulse register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_end_r <= 1'b0;
        end else begin
            frame_end_r <= frame_end_s;
        end
    end

    // Per-frame overlap counter; clearing at the frame boundary drops any same-cycle hit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overlap_cnt_r <= 16'd0;
        end else if (frame_end_s) begin
            overlap_cnt_r <= 16'd0;
        end else if (overlap_s && (overlap_cnt_r != 16'hFFFF)) begin
            overlap_cnt_r <= overlap_cnt_r + 16'd1;
        end else begin
            overlap_cnt_r <= overlap_cnt_r;
        end
    end

    // Two-flop synchronizer for the asynchronous key; idles at released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_meta_r <= 1'b1;
            key_sync_r <= 1'b1;
        end else begin
            key_meta_r <= start_key_n;
            key_sync_r <= key_meta_r;
        end
    end

    // Debounce: level follows the synced key only after a full stable interval.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb_key_n_r <= 1'b1;
            deb_cnt_r   <= {DEB_W{1'b0}};
            press_r     <= 1'b0;
        end else begin
            press_r <= 1'b0;
            if (key_sync_r == deb_key_n_r) begin
                deb_cnt_r <= {DEB_W{1'b0}};
            end else if (deb_cnt_r == DEB_LAST_C) begin
                deb_key_n_r <= key_sync_r;
                deb_cnt_r   <= {DEB_W{1'b0}};
                press_r     <= ~key_sync_r;
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
            end
        end
    end

    // Game sequencer with registered hit/flash/game_reset outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            hit_r        <= 1'b1;
            game_reset_r <= 1'b0;
            flash_r      <= 1'b0;
            frame_cnt_r  <= {FRM_W{1'b0}};
            flash_cnt_r  <= {FLS_W{1'b0}};
        end else begin
            game_reset_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (press_r) begin
                        state_r      <= ST_RUN;
                        hit_r        <= 1'b0;
                        game_reset_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (frame_end_s && collide_s) begin
                        state_r     <= ST_HIT;
                        hit_r       <= 1'b1;
                        flash_r     <= 1'b1;
                        frame_cnt_r <= {FRM_W{1'b0}};
                        flash_cnt_r <= {FLS_W{1'b0}};
                    end
                end
                ST_HIT: begin
                    if (frame_end_s) begin
                        if (frame_cnt_r == HIT_LAST_C) begin
                            state_r <= ST_GAMEOVER;
                            flash_r <= 1'b0;
                        end else begin
                            frame_cnt_r <= frame_cnt_r + FRM_W'(1);
                            if (flash_cnt_r == FLASH_LAST_C) begin
                                flash_cnt_r <= {FLS_W{1'b0}};
                                flash_r     <= ~flash_r;
                            end else begin
                                flash_cnt_r <= flash_cnt_r + FLS_W'(1);
                            end
                        end
                    end
                end
                ST_GAMEOVER: begin
                    flash_r <= 1'b0;
                    if (press_r) begin
                        state_r      <= ST_RUN;
                        hit_r        <= 1'b0;
                        game_reset_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    hit_r   <= 1'b1;
                    flash_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
